// File: rtl/mem_arbiter_if.sv
// Shared-memory-port bundle: fetch requester, data requester and memory side.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_done;
  logic [DW-1:0] f_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_done;
  logic [DW-1:0] d_rdata;
  logic          err;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output f_done, f_rdata, d_done, d_rdata, err,
           mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  f_done, f_rdata, d_done, d_rdata, err,
           mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single memory port: fetch vs. data, alternating
// under contention, with a watchdog that aborts accesses the memory never answers.
module mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   bus
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nxt;
  logic          last_d;
  logic [CW-1:0] cnt;
  logic          grant_c;
  logic          pick_d_c;
  logic          finish_c;
  logic          timeout_c;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode; D wins a tie only when F had the previous grant
  always_comb begin
    state_nxt = state;
    grant_c   = 1'b0;
    pick_d_c  = 1'b0;
    finish_c  = 1'b0;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.f_req || bus.d_req) begin
          grant_c   = 1'b1;
          pick_d_c  = bus.d_req && (!bus.f_req || !last_d);
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_rdy) begin
          finish_c  = 1'b1;
          state_nxt = DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          finish_c  = 1'b1;
          timeout_c = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Access latches double as the registered memory-side outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_d        <= 1'b0;
      cnt           <= CW'(0);
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= AW'(0);
      bus.mem_wdata <= DW'(0);
      bus.f_done    <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.f_rdata   <= DW'(0);
      bus.d_rdata   <= DW'(0);
      bus.err       <= 1'b0;
    end else begin
      bus.f_done <= 1'b0;
      bus.d_done <= 1'b0;
      if (grant_c) begin
        last_d <= pick_d_c;
        cnt    <= CW'(0);
        if (pick_d_c) begin
          bus.mem_addr  <= bus.d_addr;
          bus.mem_wdata <= bus.d_wdata;
          bus.mem_we    <= bus.d_we;
          bus.mem_re    <= ~bus.d_we;
        end else begin
          bus.mem_addr  <= bus.f_addr;
          bus.mem_wdata <= DW'(0);
          bus.mem_we    <= 1'b0;
          bus.mem_re    <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        if (finish_c) begin
          bus.mem_re <= 1'b0;
          bus.mem_we <= 1'b0;
          bus.err    <= timeout_c;
          if (last_d) begin
            bus.d_done  <= 1'b1;
            bus.d_rdata <= (bus.mem_rdy && !bus.mem_we) ? bus.mem_rdata : DW'(0);
          end else begin
            bus.f_done  <= 1'b1;
            bus.f_rdata <= bus.mem_rdy ? bus.mem_rdata : DW'(0);
          end
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single fetch, store/load, wait states,
// contention, mid-access reset, and timeout on a second short-watchdog instance.
module tb_mem_arbiter;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   wait_n;
  int   wcnt;
  logic [31:0] mem [logic [31:0]];

  mem_arbiter_if #(.AW(32), .DW(32)) b0 ();
  mem_arbiter_if #(.AW(32), .DW(32)) b1 ();

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) u_to (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    case (a)
      32'h10:  return 32'hDEADBEEF;
      32'h80:  return 32'hCAFEF00D;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory model: answers after wait_n extra cycles of an asserted enable
  always @(negedge clk) begin
    if ((b0.mem_re || b0.mem_we) && !b0.mem_rdy) begin
      if (wcnt == wait_n) begin
        b0.mem_rdy = 1'b1;
        if (b0.mem_we) begin
          mem[b0.mem_addr] = b0.mem_wdata;
          b0.mem_rdata = 32'h0;
        end else begin
          b0.mem_rdata = rd(b0.mem_addr);
        end
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      b0.mem_rdy = 1'b0;
      wcnt = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    bit found;
    bit overlap;
    errors = 0;
    checks = 0;
    wait_n = 0;
    wcnt   = 0;
    rst = 1'b0;
    b0.f_req = 0; b0.f_addr = 0; b0.d_req = 0; b0.d_we = 0; b0.d_addr = 0; b0.d_wdata = 0;
    b1.f_req = 0; b1.f_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b1.mem_rdy = 1'b0; b1.mem_rdata = 32'h0;
    step(); step();

    // Reset state
    chk("rst_mem_re", 64'(b0.mem_re), 64'h0);
    chk("rst_mem_we", 64'(b0.mem_we), 64'h0);
    chk("rst_mem_addr", 64'(b0.mem_addr), 64'h0);
    chk("rst_dones", 64'({b0.f_done, b0.d_done, b0.err}), 64'h0);
    chk("rst_rdata", 64'({b0.f_rdata, b0.d_rdata}), 64'h0);
    rst = 1'b1;
    step();

    // Single fetch, immediate rdy
    b0.f_req = 1; b0.f_addr = 32'h10;
    step();
    chk("fetch_re", 64'({b0.mem_re, b0.mem_we}), 64'h2);
    chk("fetch_addr", 64'(b0.mem_addr), 64'h10);
    step();
    chk("fetch_done", 64'({b0.f_done, b0.d_done, b0.err}), 64'h4);
    chk("fetch_rdata", 64'(b0.f_rdata), 64'hDEADBEEF);
    chk("fetch_en_off", 64'({b0.mem_re, b0.mem_we}), 64'h0);
    b0.f_req = 0;
    step();
    chk("fetch_pulse", 64'(b0.f_done), 64'h0);
    step();
    chk("idle_no_req", 64'({b0.mem_re, b0.mem_we}), 64'h0);

    // Store with two wait states, then readback load
    wait_n = 2;
    b0.d_req = 1; b0.d_we = 1; b0.d_addr = 32'h40; b0.d_wdata = 32'h12345678;
    step();
    chk("store_en", 64'({b0.mem_re, b0.mem_we}), 64'h1);
    chk("store_bus", 64'({b0.mem_addr, b0.mem_wdata}), 64'h00000040_12345678);
    n = 0;
    found = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      n++;
      if (b0.d_done) begin found = 1; break; end
    end
    chk("store_done_seen", 64'(found), 64'h1);
    chk("store_latency", 64'(n), 64'h3);
    chk("store_rdata_zero", 64'({b0.d_rdata, b0.f_done, b0.err}), 64'h0);
    b0.d_req = 0;
    step();
    wait_n = 0;
    b0.d_req = 1; b0.d_we = 0;
    step();
    chk("load_en", 64'({b0.mem_re, b0.mem_we}), 64'h2);
    step();
    chk("load_done", 64'({b0.d_done, b0.f_done}), 64'h2);
    chk("load_rdata", 64'(b0.d_rdata), 64'h12345678);
    b0.d_req = 0;
    step();
    chk("load_pulse", 64'(b0.d_done), 64'h0);

    // Wait states with requester inputs changing mid-access
    wait_n = 5;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h80; b0.d_wdata = 32'h55;
    step();
    b0.d_addr = 32'h99; b0.d_wdata = 32'hAA; b0.d_we = 1;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("ws_hold%0d", c), 64'({b0.mem_addr, b0.mem_wdata}), 64'h00000080_00000055);
      chk($sformatf("ws_en%0d", c), 64'({b0.mem_re, b0.mem_we, b0.d_done}), 64'h4);
      step();
    end
    chk("ws_done", 64'(b0.d_done), 64'h1);
    chk("ws_rdata", 64'(b0.d_rdata), 64'hCAFEF00D);
    b0.d_req = 0; b0.d_we = 0;
    step();

    // Contention from reset: D first, then strict alternation
    rst = 1'b0;
    wait_n = 0;
    b0.f_req = 1; b0.f_addr = 32'h10;
    b0.d_req = 1; b0.d_we = 0; b0.d_addr = 32'h40;
    step();
    rst = 1'b1;
    overlap = 0;
    for (int k = 0; k < 8; k++) begin
      found = 0;
      for (int c = 0; c < 10; c++) begin
        step();
        if (b0.f_done && b0.d_done) overlap = 1;
        if (b0.f_done || b0.d_done) begin found = 1; break; end
      end
      chk($sformatf("cont_seen%0d", k), 64'(found), 64'h1);
      chk($sformatf("cont_order%0d", k), 64'({b0.d_done, b0.f_done}), (k % 2 == 0) ? 64'h2 : 64'h1);
      chk($sformatf("cont_data%0d", k), 64'((k % 2 == 0) ? b0.d_rdata : b0.f_rdata),
          (k % 2 == 0) ? 64'h12345678 : 64'hDEADBEEF);
    end
    chk("cont_overlap", 64'(overlap), 64'h0);
    b0.f_req = 0; b0.d_req = 0;
    step(); step();

    // Reset mid-access: asynchronous clear, no done pulse
    wait_n = 10;
    b0.f_req = 1; b0.f_addr = 32'h10;
    step();
    chk("mid_access", 64'(b0.mem_re), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_clear", 64'({b0.mem_re, b0.mem_we, b0.err, b0.f_done, b0.d_done}), 64'h0);
    chk("async_bus", 64'({b0.mem_addr, b0.f_rdata}), 64'h0);
    wait_n = 0;
    found = 0;
    for (int c = 0; c < 3; c++) begin
      step();
      if (b0.f_done || b0.d_done) found = 1;
    end
    chk("no_done_in_rst", 64'(found), 64'h0);
    rst = 1'b1;
    step();
    chk("post_rst_re", 64'({b0.mem_re, b0.mem_addr}), 64'h1_00000010);
    step();
    chk("post_rst_done", 64'({b0.f_done, b0.err}), 64'h2);
    chk("post_rst_rdata", 64'(b0.f_rdata), 64'hDEADBEEF);
    b0.f_req = 0;
    step();

    // Timeout: memory never answers, watchdog of 4 cycles
    b1.f_req = 1; b1.f_addr = 32'h20;
    step();
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (b1.f_done) break;
      if (b1.mem_re) n++;
      step();
    end
    chk("to_re_cycles", 64'(n), 64'h4);
    chk("to_done_err", 64'({b1.f_done, b1.err, b1.d_done}), 64'h6);
    chk("to_rdata", 64'(b1.f_rdata), 64'h0);
    b1.f_req = 0;
    step();
    chk("to_idle", 64'({b1.mem_re, b1.f_done, b1.err}), 64'h1);
    step();
    chk("to_quiet", 64'({b1.mem_re, b1.mem_we}), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single memory port between two requesters: instruction fetch (F) and data load/store (D, driven from the data-move path).
- Replaces the combinational fetch/mem_addr mux and the ad-hoc read/write enables with a sequenced FSM.
- Grants one requester at a time, holds the access stable until the memory asserts rdy, then returns read data with a one-cycle done pulse.
- Includes a watchdog timeout that flags a memory that never answers.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 255, cycles in ACCESS without mem_rdy before the access is aborted; range 1 to 65535.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- f_req  in  1  fetch request, level, held until f_done
- f_addr  in  AW  fetch address
- f_done  out  1  one-cycle pulse, fetch access complete
- f_rdata  out  DW  fetched word, valid while f_done=1
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_done  out  1  one-cycle pulse, data access complete
- d_rdata  out  DW  load word, valid while d_done=1
- err  out  1  high with the done pulse when the access timed out
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_rdy=1
- mem_rdy  in  1  memory ready/complete

Behaviour:
- States: IDLE, ACCESS, DONE. State, latches and counter are all registered.
- Reset (rst=0, asynchronous):
  - state=IDLE, last_d=0, counter=0.
  - All outputs 0: mem_re, mem_we, mem_addr, mem_wdata, f_done, d_done, f_rdata, d_rdata, err.
  - Asserting reset mid-access abandons the access with no done pulse.
- IDLE:
  - No request: stay, all memory enables 0.
  - One request: grant it.
  - Both requests: alternate. Grant D if last_d=0, else F. last_d is updated on every grant (1 for D, 0 for F).
  - On grant, latch the requester's address, we, wdata and id at the edge, then go to ACCESS. The counter clears to 0.
- ACCESS:
  - mem_addr and mem_wdata come from the latches.
  - F grant: mem_re=1. D grant: mem_re=~we, mem_we=we. The enables are decoded from state plus latches, with no combinational path from req inputs.
  - Latched values stay stable for the whole access, even if the requester changes or drops its inputs.
  - Edge with mem_rdy=1: capture mem_rdata into the granted requester's rdata register (stores capture 0), clear err, go to DONE.
  - Edge with mem_rdy=0: counter increments. When counter reaches TIMEOUT-1 and mem_rdy=0, go to DONE with err=1 and rdata=0.
  - A requester dropping req during ACCESS does not abort; the access completes and done still pulses.
- DONE:
  - The granted requester's done=1 for exactly this cycle; err is valid alongside it.
  - Memory enables are 0.
  - Requests are ignored. Next edge goes to IDLE.
  - rdata and err hold until the next done.
- Latency:
  - Request first sampled at edge E0, mem_rdy at edge E1 gives done high between E1 and E2.
  - Minimum 2 edges from request to done; peak throughput one access per 3 cycles.
- Requester rule: drop req the cycle done is seen. A req still high in IDLE is treated as a new request.
- Invariants: never mem_re and mem_we together; never f_done and d_done together.

Test Plan:
- Single fetch: f_req=1, f_addr=0x10, memory answers rdy one cycle later with 0xDEADBEEF -> mem_re=1 with mem_addr=0x10 for one cycle; f_done pulses once with f_rdata=0xDEADBEEF and err=0; d_done stays 0.
- Store: d_req=1, d_we=1, d_addr=0x40, d_wdata=0x12345678 -> mem_we=1 and mem_re=0 with those values until rdy; d_done pulses once; readback by a load of 0x40 returns 0x12345678.
- Contention: f_req and d_req held high continuously from reset -> grants alternate D,F,D,F; each done is followed by the other requester's access; no done overlap across 8 accesses.
- Wait states: memory delays rdy by 5 cycles, and d_addr/d_wdata change mid-access -> mem_addr and mem_wdata stay at the latched values for all 6 ACCESS cycles; done arrives 1 cycle after rdy.
- Timeout: TIMEOUT=4, mem_rdy tied 0, f_req=1 -> mem_re high 4 cycles; f_done=1 with err=1 and f_rdata=0; then IDLE.
- Reset mid-access: assert rst=0 during ACCESS -> all outputs 0 immediately, asynchronously; no done pulse. After release with f_req=1, a clean fetch completes normally.
